// File: rtl/rv_prog_loader_if.sv
// Bundle between the program loader and its surroundings: the command/data word
// stream in, and the imem/dmem write ports plus start-PC handshake toward the core.
interface rv_prog_loader_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] s_data;
    logic            s_valid;
    logic            s_ready;

    logic [XLEN-1:0] imem_wr_addr;
    logic [XLEN-1:0] imem_wr_data;
    logic            imem_wr_valid;

    logic [XLEN-1:0] dmem_wr_addr;
    logic [XLEN-1:0] dmem_wr_data;
    logic            dmem_wr_valid;

    logic            pc_valid_o;
    logic [XLEN-1:0] pc_start_minus4;

    // The loader side: consumes the stream, drives memory writes and the start PC.
    modport master (
        input  s_data, s_valid,
        output s_ready,
        output imem_wr_addr, imem_wr_data, imem_wr_valid,
        output dmem_wr_addr, dmem_wr_data, dmem_wr_valid,
        output pc_valid_o, pc_start_minus4
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready,
        input  imem_wr_addr, imem_wr_data, imem_wr_valid,
        input  dmem_wr_addr, dmem_wr_data, dmem_wr_valid,
        input  pc_valid_o, pc_start_minus4
    );
endinterface

// File: rtl/rv_prog_loader.sv
// Host-side program loader: decodes LOAD_IMEM/LOAD_DMEM/START commands from a word stream.
// Optional trailing-checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module rv_prog_loader #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rv_prog_loader_if.master  bus,
    output logic              busy,
    output logic              err_opcode,
`ifdef LOADER_CHECKSUM_EN
    output logic              err_csum,
`endif
    output logic              err_align
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        ENTRY,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        RUN
    } stateT;

    stateT            state;
    logic [CNT_W-1:0] wordCnt;
    logic [XLEN-1:0]  curAddr;
    logic             toDmem;
`ifdef LOADER_CHECKSUM_EN
    logic [XLEN-1:0]  csumAcc;
`endif

    logic            beat;
    logic [7:0]      opcode;
    logic [XLEN-1:0] alignedWord;
    logic            misaligned;

    assign beat        = bus.s_valid && bus.s_ready;
    assign opcode      = bus.s_data[XLEN-1 -: 8];
    assign alignedWord = {bus.s_data[XLEN-1:2], 2'b00};
    assign misaligned  = (bus.s_data[1:0] != 2'b00);

    // Single registered FSM; every output is a flop so the core sees glitch-free strobes.
    // Strobes default low each cycle, giving exactly one pulse per accepted data beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            wordCnt             <= '0;
            curAddr             <= '0;
            toDmem              <= 1'b0;
            busy                <= 1'b0;
            err_opcode          <= 1'b0;
            err_align           <= 1'b0;
            bus.s_ready         <= 1'b0;
            bus.imem_wr_addr    <= '0;
            bus.imem_wr_data    <= '0;
            bus.imem_wr_valid   <= 1'b0;
            bus.dmem_wr_addr    <= '0;
            bus.dmem_wr_data    <= '0;
            bus.dmem_wr_valid   <= 1'b0;
            bus.pc_valid_o      <= 1'b0;
            bus.pc_start_minus4 <= '0;
`ifdef LOADER_CHECKSUM_EN
            csumAcc             <= '0;
            err_csum            <= 1'b0;
`endif
        end else begin
            bus.imem_wr_valid <= 1'b0;
            bus.dmem_wr_valid <= 1'b0;
            bus.s_ready       <= (state != RUN);
            if (beat) begin
                unique case (state)
                    IDLE: begin
                        if (opcode == 8'h01 || opcode == 8'h02) begin
                            toDmem  <= (opcode == 8'h02);
                            wordCnt <= bus.s_data[CNT_W-1:0];
`ifdef LOADER_CHECKSUM_EN
                            csumAcc <= '0;
`endif
                            state   <= ADDR;
                            busy    <= 1'b1;
                        end else if (opcode == 8'h03) begin
                            state <= ENTRY;
                            busy  <= 1'b1;
                        end else begin
                            err_opcode <= 1'b1;
                        end
                    end
                    ADDR: begin
                        curAddr <= alignedWord;
                        if (misaligned) err_align <= 1'b1;
                        if (wordCnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (toDmem) begin
                            bus.dmem_wr_addr  <= curAddr;
                            bus.dmem_wr_data  <= bus.s_data;
                            bus.dmem_wr_valid <= 1'b1;
                        end else begin
                            bus.imem_wr_addr  <= curAddr;
                            bus.imem_wr_data  <= bus.s_data;
                            bus.imem_wr_valid <= 1'b1;
                        end
                        curAddr <= curAddr + XLEN'(4);
                        wordCnt <= wordCnt - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        csumAcc <= csumAcc + bus.s_data;
                        if (wordCnt == CNT_W'(1)) state <= CSUM;
`else
                        if (wordCnt == CNT_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`endif
                    end
`ifdef LOADER_CHECKSUM_EN
                    CSUM: begin
                        if (bus.s_data != csumAcc) err_csum <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`endif
                    ENTRY: begin
                        if (misaligned) err_align <= 1'b1;
                        busy <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        // A corrupted image must never be started; swallow the entry word.
                        if (err_csum) begin
                            state <= IDLE;
                        end else begin
                            bus.pc_start_minus4 <= alignedWord - XLEN'(4);
                            bus.pc_valid_o      <= 1'b1;
                            bus.s_ready         <= 1'b0;
                            state               <= RUN;
                        end
`else
                        bus.pc_start_minus4 <= alignedWord - XLEN'(4);
                        bus.pc_valid_o      <= 1'b1;
                        bus.s_ready         <= 1'b0;
                        state               <= RUN;
`endif
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv_prog_loader.sv
// Directed table-driven bench for rv_prog_loader; expected outputs are hand-computed.
module tb_rv_prog_loader;

    typedef struct packed {
        logic        imV;
        logic [31:0] imA;
        logic [31:0] imD;
        logic        dmV;
        logic [31:0] dmA;
        logic [31:0] dmD;
        logic        busy;
        logic        ready;
        logic        errOp;
        logic        errAl;
        logic        pcV;
        logic [31:0] pc;
    } outT;

    typedef struct {
        logic        v;
        logic [31:0] d;
        outT         e;
    } vecT;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic busy;
    logic errOpcode;
    logic errAlign;
`ifdef LOADER_CHECKSUM_EN
    logic errCsum;
`endif

    int nVec;
    int nMis;
    vecT vecs[$];

    rv_prog_loader_if #(.XLEN(32)) bus ();

    rv_prog_loader #(.XLEN(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .err_opcode (errOpcode),
`ifdef LOADER_CHECKSUM_EN
        .err_csum   (errCsum),
`endif
        .err_align  (errAlign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outT mkOut(logic imV, logic [31:0] imA, logic [31:0] imD,
                                  logic dmV, logic [31:0] dmA, logic [31:0] dmD,
                                  logic bsy, logic rdy, logic eo, logic ea,
                                  logic pv, logic [31:0] pc);
        outT o;
        o = '{imV, imA, imD, dmV, dmA, dmD, bsy, rdy, eo, ea, pv, pc};
        return o;
    endfunction

    function automatic outT sample();
        return mkOut(bus.imem_wr_valid, bus.imem_wr_addr, bus.imem_wr_data,
                     bus.dmem_wr_valid, bus.dmem_wr_addr, bus.dmem_wr_data,
                     busy, bus.s_ready, errOpcode, errAlign,
                     bus.pc_valid_o, bus.pc_start_minus4);
    endfunction

    task automatic addVec(input logic v, input logic [31:0] d, input outT e);
        vecT x;
        x.v = v;
        x.d = d;
        x.e = e;
        vecs.push_back(x);
    endtask

    // Address/data fields only matter while their strobe is expected.
    task automatic checkOutput(input string name, input outT exp);
        outT act;
        outT expM;
        act  = sample();
        expM = exp;
        if (!exp.imV) begin act.imA = '0; act.imD = '0; expM.imA = '0; expM.imD = '0; end
        if (!exp.dmV) begin act.dmA = '0; act.dmD = '0; expM.dmA = '0; expM.dmD = '0; end
        nVec++;
        if (act !== expM) begin
            nMis++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expM);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d);
        bus.s_valid = v;
        bus.s_data  = d;
        @(posedge clk);
        #1;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic checkCsum(input string name, input logic exp);
        nVec++;
        if (errCsum !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: err_csum got %b expected %b", name, errCsum, exp);
        end
    endtask
`endif

    task automatic resetAndIdle(input string name);
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        rst_n = 1'b0;
        #3;
        checkOutput({name, "_inReset"}, mkOut(0,0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0);
        checkOutput({name, "_idleReady"}, mkOut(0,0,0,0,0,0,0,1,0,0,0,0));
    endtask

    initial begin
        nVec = 0;
        nMis = 0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        rst_n = 1'b0;
        #12;
        resetAndIdle("reset");

`ifdef LOADER_CHECKSUM_EN
        addVec(1, 32'h01000002, mkOut(0,0,0,0,0,0,1,1,0,0,0,0));
        addVec(1, 32'h00000100, mkOut(0,0,0,0,0,0,1,1,0,0,0,0));
        addVec(1, 32'h00000001, mkOut(1,32'h100,32'h1,0,0,0,1,1,0,0,0,0));
        addVec(1, 32'h00000002, mkOut(1,32'h104,32'h2,0,0,0,1,1,0,0,0,0));
        addVec(1, 32'h00000003, mkOut(0,0,0,0,0,0,0,1,0,0,0,0));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].d);
            checkOutput($sformatf("csumGood%0d", i), vecs[i].e);
        end
        checkCsum("csumGoodFlag", 1'b0);
        vecs.delete();
        addVec(1, 32'h02000001, mkOut(0,0,0,0,0,0,1,1,0,0,0,0));
        addVec(1, 32'h00000200, mkOut(0,0,0,0,0,0,1,1,0,0,0,0));
        addVec(1, 32'h00000005, mkOut(0,0,0,1,32'h200,32'h5,1,1,0,0,0,0));
        addVec(1, 32'h00000006, mkOut(0,0,0,0,0,0,0,1,0,0,0,0));
        addVec(1, 32'h03000000, mkOut(0,0,0,0,0,0,1,1,0,0,0,0));
        addVec(1, 32'h00000200, mkOut(0,0,0,0,0,0,0,1,0,0,0,0));
        addVec(0, 32'h00000000, mkOut(0,0,0,0,0,0,0,1,0,0,0,0));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].d);
            checkOutput($sformatf("csumBad%0d", i), vecs[i].e);
        end
        checkCsum("csumBadFlag", 1'b1);
`else
        // Bad opcode, imem load, stalled dmem load, misaligned base, N=0, wrap, start.
        addVec(1, 32'h7F000000, mkOut(0,0,0,0,0,0,0,1,1,0,0,0));
        addVec(1, 32'h01000003, mkOut(0,0,0,0,0,0,1,1,1,0,0,0));
        addVec(1, 32'h00000100, mkOut(0,0,0,0,0,0,1,1,1,0,0,0));
        addVec(1, 32'h11111111, mkOut(1,32'h100,32'h11111111,0,0,0,1,1,1,0,0,0));
        addVec(1, 32'h22222222, mkOut(1,32'h104,32'h22222222,0,0,0,1,1,1,0,0,0));
        addVec(1, 32'h33333333, mkOut(1,32'h108,32'h33333333,0,0,0,0,1,1,0,0,0));
        addVec(0, 32'h00000000, mkOut(0,0,0,0,0,0,0,1,1,0,0,0));
        addVec(1, 32'h02000002, mkOut(0,0,0,0,0,0,1,1,1,0,0,0));
        addVec(1, 32'h00002000, mkOut(0,0,0,0,0,0,1,1,1,0,0,0));
        addVec(1, 32'hDEADBEEF, mkOut(0,0,0,1,32'h2000,32'hDEADBEEF,1,1,1,0,0,0));
        addVec(0, 32'h12345678, mkOut(0,0,0,0,0,0,1,1,1,0,0,0));
        addVec(0, 32'h12345678, mkOut(0,0,0,0,0,0,1,1,1,0,0,0));
        addVec(0, 32'h12345678, mkOut(0,0,0,0,0,0,1,1,1,0,0,0));
        addVec(1, 32'hCAFEF00D, mkOut(0,0,0,1,32'h2004,32'hCAFEF00D,0,1,1,0,0,0));
        addVec(1, 32'h01000001, mkOut(0,0,0,0,0,0,1,1,1,0,0,0));
        addVec(1, 32'h00000102, mkOut(0,0,0,0,0,0,1,1,1,1,0,0));
        addVec(1, 32'h44444444, mkOut(1,32'h100,32'h44444444,0,0,0,0,1,1,1,0,0));
        addVec(1, 32'h02000000, mkOut(0,0,0,0,0,0,1,1,1,1,0,0));
        addVec(1, 32'h00003000, mkOut(0,0,0,0,0,0,0,1,1,1,0,0));
        addVec(1, 32'h01000002, mkOut(0,0,0,0,0,0,1,1,1,1,0,0));
        addVec(1, 32'hFFFFFFFC, mkOut(0,0,0,0,0,0,1,1,1,1,0,0));
        addVec(1, 32'h55555555, mkOut(1,32'hFFFFFFFC,32'h55555555,0,0,0,1,1,1,1,0,0));
        addVec(1, 32'h66666666, mkOut(1,32'h00000000,32'h66666666,0,0,0,0,1,1,1,0,0));
        addVec(1, 32'h03000000, mkOut(0,0,0,0,0,0,1,1,1,1,0,0));
        addVec(1, 32'h00000200, mkOut(0,0,0,0,0,0,0,0,1,1,1,32'h1FC));
        addVec(1, 32'h77777777, mkOut(0,0,0,0,0,0,0,0,1,1,1,32'h1FC));
        addVec(1, 32'h01000001, mkOut(0,0,0,0,0,0,0,0,1,1,1,32'h1FC));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].d);
            checkOutput($sformatf("vec%0d", i), vecs[i].e);
        end
`endif

        // Reset in the middle of a 4-word load: everything clears at once, no late strobes.
        resetAndIdle("midReset");
        applyStimulus(1, 32'h01000004);
        checkOutput("midHdr", mkOut(0,0,0,0,0,0,1,1,0,0,0,0));
        applyStimulus(1, 32'h00000400);
        checkOutput("midBase", mkOut(0,0,0,0,0,0,1,1,0,0,0,0));
        applyStimulus(1, 32'h88888888);
        checkOutput("midBeat1", mkOut(1,32'h400,32'h88888888,0,0,0,1,1,0,0,0,0));
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h99999999;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midAsync", mkOut(0,0,0,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("midHeld%0d", i), mkOut(0,0,0,0,0,0,0,0,0,0,0,0));
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0);
        checkOutput("postIdle", mkOut(0,0,0,0,0,0,0,1,0,0,0,0));
        applyStimulus(1, 32'h02000001);
        checkOutput("postHdr", mkOut(0,0,0,0,0,0,1,1,0,0,0,0));
        applyStimulus(1, 32'h00000500);
        checkOutput("postBase", mkOut(0,0,0,0,0,0,1,1,0,0,0,0));
        applyStimulus(1, 32'hAAAAAAAA);
        checkOutput("postData", mkOut(0,0,0,1,32'h500,32'hAAAAAAAA,CSUM_ON,1,0,0,0,0));
        applyStimulus(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
